// File: rtl/fir_tcdm_responder.sv
// rtl/fir_tcdm_responder.sv - word-interleaved multi-bank TCDM responder
// Per-bank round-robin arbitration, single-cycle SRAM banks, fixed 1-cycle response.
module fir_tcdm_responder #(
    parameter int MP         = 4,
    parameter int NB         = 8,
    parameter int BANK_WORDS = 256
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [MP-1:0]    tcdm_req,
    output logic [MP-1:0]    tcdm_gnt,
    input  logic [MP*32-1:0] tcdm_add,
    input  logic [MP-1:0]    tcdm_wen,
    input  logic [MP*4-1:0]  tcdm_be,
    input  logic [MP*32-1:0] tcdm_data,
    output logic [MP*32-1:0] tcdm_r_data,
    output logic [MP-1:0]    tcdm_r_valid,
    input  logic [NB-1:0]    stall_i
);

    localparam int NB_W = $clog2(NB);
    localparam int RW   = $clog2(BANK_WORDS);
    localparam int PW   = (MP > 1) ? $clog2(MP) : 1;
    localparam int IW   = NB_W + RW;

    logic [31:0]     mem [NB*BANK_WORDS];
    logic [NB_W-1:0] port_bank [MP];
    logic [IW-1:0]   word_idx  [MP];
    logic [31:0]     rd_word   [MP];
    logic [PW-1:0]   rr_ptr    [NB];
    logic [PW-1:0]   rr_next   [NB];
    logic [MP-1:0]   gnt;
    logic [MP-1:0]   hs;
    logic            unused_add;

    // Byte-offset bits and aliasing high bits are intentionally ignored.
    assign unused_add = ^tcdm_add;

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            port_bank[p] = tcdm_add[p*32+2 +: NB_W];
            word_idx[p]  = {tcdm_add[p*32+2+NB_W +: RW], tcdm_add[p*32+2 +: NB_W]};
            rd_word[p]   = mem[word_idx[p]];
        end
    end

    always_comb begin : arb
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int b = 0; b < NB; b++) begin
            rr_next[b] = rr_ptr[b];
            found      = 1'b0;
            // Scan ports starting at the bank's pointer, wrapping MP-1 -> 0.
            for (int i = 0; i < MP; i++) begin
                sum = {1'b0, rr_ptr[b]} + (PW+1)'(i);
                if (sum >= (PW+1)'(MP))
                    sum = sum - (PW+1)'(MP);
                idx = sum[PW-1:0];
                if (!found && !stall_i[b] && tcdm_req[idx] &&
                    port_bank[idx] == NB_W'(b)) begin
                    found      = 1'b1;
                    gnt[idx]   = 1'b1;
                    rr_next[b] = (idx == PW'(MP-1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end

    assign tcdm_gnt = gnt & {MP{rst_ni}};
    assign hs       = tcdm_gnt & tcdm_req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NB; b++)
                rr_ptr[b] <= '0;
            tcdm_r_valid <= '0;
            tcdm_r_data  <= '0;
        end else begin
            for (int b = 0; b < NB; b++)
                rr_ptr[b] <= rr_next[b];
            tcdm_r_valid <= hs;
            for (int p = 0; p < MP; p++)
                tcdm_r_data[p*32 +: 32] <= (hs[p] && tcdm_wen[p]) ? rd_word[p] : 32'h0;
        end
    end

    // SRAM contents survive reset; distinct banks may be written in the same cycle.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (hs[p] && !tcdm_wen[p]) begin
                for (int i = 0; i < 4; i++) begin
                    if (tcdm_be[p*4+i])
                        mem[word_idx[p]][i*8 +: 8] <= tcdm_data[p*32+i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tcdm_responder.sv
// tb/tb_fir_tcdm_responder.sv - directed self-checking bench for fir_tcdm_responder
module tb_fir_tcdm_responder;

    localparam int MP = 4;
    localparam int NB = 8;
    localparam int BW = 256;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [MP-1:0]    tcdm_req;
    logic [MP-1:0]    tcdm_gnt;
    logic [MP*32-1:0] tcdm_add;
    logic [MP-1:0]    tcdm_wen;
    logic [MP*4-1:0]  tcdm_be;
    logic [MP*32-1:0] tcdm_data;
    logic [MP*32-1:0] tcdm_r_data;
    logic [MP-1:0]    tcdm_r_valid;
    logic [NB-1:0]    stall_i;

    int checks   = 0;
    int failures = 0;

    fir_tcdm_responder #(.MP(MP), .NB(NB), .BANK_WORDS(BW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tcdm_req     (tcdm_req),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_data    (tcdm_data),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .stall_i      (stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input int p, input logic rq, input logic [31:0] a,
                         input logic we, input logic [3:0] b, input logic [31:0] d);
        tcdm_req[p]          = rq;
        tcdm_add[p*32 +: 32] = a;
        tcdm_wen[p]          = we;
        tcdm_be[p*4 +: 4]    = b;
        tcdm_data[p*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt got=%h exp=%h", tcdm_gnt, 4'b0000);
        end
        checks++;
        if (tcdm_r_valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_r_valid got=%h exp=%h", tcdm_r_valid, 4'b0000);
        end
        checks++;
        if (tcdm_r_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_r_data got=%h exp=0", tcdm_r_data);
        end
        tcdm_req = '0;
        rst_ni   = 1'b1;
        step();
    endtask

    task automatic test_conflict();
        for (int p = 0; p < MP; p++)
            drive(p, 1'b1, 32'(p * 32), 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < MP; k++) begin
            @(negedge clk_i);
            checks++;
            if (tcdm_gnt !== 4'(1 << k)) begin
                failures++;
                $display("FAIL conflict_gnt%0d got=%h exp=%h", k, tcdm_gnt, 4'(1 << k));
            end
            step();
            checks++;
            if (tcdm_r_valid !== 4'(1 << k)) begin
                failures++;
                $display("FAIL conflict_r_valid%0d got=%h exp=%h", k, tcdm_r_valid, 4'(1 << k));
            end
            tcdm_req[k] = 1'b0;
        end
        step();
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wr_gnt got=%h exp=%h", tcdm_gnt, 4'b0001);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0001 || tcdm_r_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL wr_resp got=%h/%h exp=1/00000000", tcdm_r_valid, tcdm_r_data[31:0]);
        end
        drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL rd_gnt got=%h exp=%h", tcdm_gnt, 4'b0001);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0001 || tcdm_r_data[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_resp got=%h/%h exp=1/deadbeef", tcdm_r_valid, tcdm_r_data[31:0]);
        end
        tcdm_req = '0;
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0000 || tcdm_r_data !== 128'h0) begin
            failures++;
            $display("FAIL idle_resp got=%h/%h exp=0/0", tcdm_r_valid, tcdm_r_data);
        end
    endtask

    task automatic test_byte_enable();
        drive(0, 1'b1, 32'h40, 1'b0, 4'b0101, 32'h11223344);
        step();
        drive(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0001 || tcdm_r_data[31:0] !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL be_readback got=%h/%h exp=1/de22be44", tcdm_r_valid, tcdm_r_data[31:0]);
        end
        tcdm_req = '0;
        step();
    endtask

    task automatic test_parallel();
        for (int p = 0; p < MP; p++)
            drive(p, 1'b1, 32'(p * 4), 1'b0, 4'hF, 32'hA0000000 + 32'(p));
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'hF) begin
            failures++;
            $display("FAIL par_wr_gnt got=%h exp=f", tcdm_gnt);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'hF || tcdm_r_data !== 128'h0) begin
            failures++;
            $display("FAIL par_wr_resp got=%h/%h exp=f/0", tcdm_r_valid, tcdm_r_data);
        end
        for (int p = 0; p < MP; p++)
            drive(p, 1'b1, 32'(p * 4), 1'b1, 4'h0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'hF) begin
            failures++;
            $display("FAIL par_rd_gnt got=%h exp=f", tcdm_gnt);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'hF) begin
            failures++;
            $display("FAIL par_rd_valid got=%h exp=f", tcdm_r_valid);
        end
        for (int p = 0; p < MP; p++) begin
            checks++;
            if (tcdm_r_data[p*32 +: 32] !== 32'hA0000000 + 32'(p)) begin
                failures++;
                $display("FAIL par_rd_data%0d got=%h exp=%h", p, tcdm_r_data[p*32 +: 32],
                         32'hA0000000 + 32'(p));
            end
        end
        tcdm_req = '0;
        step();
    endtask

    task automatic test_stall_alias();
        stall_i = 8'h02;
        drive(2, 1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (tcdm_gnt !== 4'b0000) begin
                failures++;
                $display("FAIL stall_gnt%0d got=%h exp=0", c, tcdm_gnt);
            end
            step();
            checks++;
            if (tcdm_r_valid !== 4'b0000) begin
                failures++;
                $display("FAIL stall_r_valid%0d got=%h exp=0", c, tcdm_r_valid);
            end
        end
        stall_i = '0;
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0100) begin
            failures++;
            $display("FAIL unstall_gnt got=%h exp=4", tcdm_gnt);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0100 || tcdm_r_data[95:64] !== 32'hA0000001) begin
            failures++;
            $display("FAIL unstall_resp got=%h/%h exp=4/a0000001", tcdm_r_valid, tcdm_r_data[95:64]);
        end
        tcdm_req = '0;
        drive(0, 1'b1, 32'h2004, 1'b0, 4'hF, 32'hCAFEF00D);
        step();
        tcdm_req = '0;
        drive(1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0010) begin
            failures++;
            $display("FAIL alias_gnt got=%h exp=2", tcdm_gnt);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0010 || tcdm_r_data[63:32] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL alias_resp got=%h/%h exp=2/cafef00d", tcdm_r_valid, tcdm_r_data[63:32]);
        end
        tcdm_req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL mid_pre_gnt got=%h exp=1", tcdm_gnt);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        for (int p = 0; p < MP; p++)
            drive(p, 1'b1, 32'h4 + 32'(p * 32), 1'b1, 4'h0, 32'h0);
        #1;
        checks++;
        if (tcdm_r_valid !== 4'b0000 || tcdm_r_data !== 128'h0) begin
            failures++;
            $display("FAIL mid_drop got=%h/%h exp=0/0", tcdm_r_valid, tcdm_r_data);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (tcdm_gnt !== 4'b0000 || tcdm_r_valid !== 4'b0000) begin
                failures++;
                $display("FAIL mid_hold%0d got=%h/%h exp=0/0", c, tcdm_gnt, tcdm_r_valid);
            end
        end
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0001) begin
            failures++;
            $display("FAIL post_rst_gnt0 got=%h exp=1", tcdm_gnt);
        end
        step();
        checks++;
        if (tcdm_r_valid !== 4'b0001 || tcdm_r_data[31:0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL post_rst_resp got=%h/%h exp=1/cafef00d", tcdm_r_valid, tcdm_r_data[31:0]);
        end
        tcdm_req[0] = 1'b0;
        @(negedge clk_i);
        checks++;
        if (tcdm_gnt !== 4'b0010) begin
            failures++;
            $display("FAIL post_rst_gnt1 got=%h exp=2", tcdm_gnt);
        end
        tcdm_req = '0;
        step();
    endtask

    initial begin
        rst_ni    = 1'b1;
        tcdm_req  = '0;
        tcdm_add  = '0;
        tcdm_wen  = '0;
        tcdm_be   = '0;
        tcdm_data = '0;
        stall_i   = '0;
        #1;
        rst_ni = 1'b0;
        test_reset();
        test_conflict();
        test_write_read();
        test_byte_enable();
        test_parallel();
        test_stall_alias();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
